// File: rtl/jtag_reg_master_if.sv
// rtl/jtag_reg_master_if.sv - request FIFO, register bus and status signals of jtag_reg_master
interface jtag_reg_master_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic                  bus_rd_wr_L;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wr_data;
    logic [DATA_WIDTH-1:0] bus_rd_data;
    logic                  bus_rd_vld;
    logic                  reg_req;
    logic                  reg_rd_wr_L;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic                  reg_ack;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic                  busy;
    logic [7:0]            timeout_count;

    modport master (
        input  fifo_empty, bus_rd_wr_L, bus_addr, bus_wr_data, reg_ack, reg_rd_data,
        output fifo_rd_en, bus_rd_data, bus_rd_vld, reg_req, reg_rd_wr_L, reg_addr,
               reg_wr_data, busy, timeout_count
    );

    modport slave (
        output fifo_empty, bus_rd_wr_L, bus_addr, bus_wr_data, reg_ack, reg_rd_data,
        input  fifo_rd_en, bus_rd_data, bus_rd_vld, reg_req, reg_rd_wr_L, reg_addr,
               reg_wr_data, busy, timeout_count
    );
endinterface

// File: rtl/jtag_reg_master.sv
// rtl/jtag_reg_master.sv - pops JTAG register requests and runs them on the core register bus
module jtag_reg_master #(
    parameter int                             CPCI_NF2_ADDR_WIDTH = 27,
    parameter int                             CPCI_NF2_DATA_WIDTH = 32,
    parameter int                             TIMEOUT_CYCLES      = 255,
    parameter logic [CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_DATA        = 32'hDEAD_0000
) (
    input  logic               core_clk,
    input  logic               reset_n,
    jtag_reg_master_if.master  bus
);
    localparam int AW = CPCI_NF2_ADDR_WIDTH;
    localparam int DW = CPCI_NF2_DATA_WIDTH;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            reg_req_q, reg_req_d;
    logic            fifo_rd_en_q, fifo_rd_en_d;
    logic            reg_rd_wr_L_q, reg_rd_wr_L_d;
    logic [AW-1:0]   reg_addr_q, reg_addr_d;
    logic [DW-1:0]   reg_wr_data_q, reg_wr_data_d;
    logic [DW-1:0]   bus_rd_data_q, bus_rd_data_d;
    logic            bus_rd_vld_q, bus_rd_vld_d;
    logic [15:0]     wait_cnt_q, wait_cnt_d;
    logic [7:0]      timeout_count_q, timeout_count_d;

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            reg_req_q       <= 1'b0;
            fifo_rd_en_q    <= 1'b0;
            reg_rd_wr_L_q   <= 1'b1;
            reg_addr_q      <= '0;
            reg_wr_data_q   <= '0;
            bus_rd_data_q   <= '0;
            bus_rd_vld_q    <= 1'b0;
            wait_cnt_q      <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            reg_req_q       <= reg_req_d;
            fifo_rd_en_q    <= fifo_rd_en_d;
            reg_rd_wr_L_q   <= reg_rd_wr_L_d;
            reg_addr_q      <= reg_addr_d;
            reg_wr_data_q   <= reg_wr_data_d;
            bus_rd_data_q   <= bus_rd_data_d;
            bus_rd_vld_q    <= bus_rd_vld_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        reg_req_d       = reg_req_q;
        fifo_rd_en_d    = 1'b0;
        reg_rd_wr_L_d   = reg_rd_wr_L_q;
        reg_addr_d      = reg_addr_q;
        reg_wr_data_d   = reg_wr_data_q;
        bus_rd_data_d   = bus_rd_data_q;
        bus_rd_vld_d    = 1'b0;
        wait_cnt_d      = wait_cnt_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (!bus.fifo_empty) begin
                    reg_rd_wr_L_d = bus.bus_rd_wr_L;
                    reg_addr_d    = bus.bus_addr;
                    reg_wr_data_d = bus.bus_wr_data;
                    reg_req_d     = 1'b1;
                    fifo_rd_en_d  = 1'b1;
                    state_d       = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                // Ack is tested before the timeout so a last-cycle ack still returns real data.
                if (bus.reg_ack) begin
                    reg_req_d = 1'b0;
                    if (reg_rd_wr_L_q) begin
                        bus_rd_data_d = bus.reg_rd_data;
                        bus_rd_vld_d  = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    reg_req_d = 1'b0;
                    if (timeout_count_q != 8'hFF) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                    if (reg_rd_wr_L_q) begin
                        bus_rd_data_d = TIMEOUT_DATA;
                        bus_rd_vld_d  = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    state_d    = S_WAIT;
                end
            end
            // One settle cycle lets the show-ahead FIFO head update after the pop.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.fifo_rd_en    = fifo_rd_en_q;
    assign bus.reg_req       = reg_req_q;
    assign bus.reg_rd_wr_L   = reg_rd_wr_L_q;
    assign bus.reg_addr      = reg_addr_q;
    assign bus.reg_wr_data   = reg_wr_data_q;
    assign bus.bus_rd_data   = bus_rd_data_q;
    assign bus.bus_rd_vld    = bus_rd_vld_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.timeout_count = timeout_count_q;
endmodule

// File: tb/tb_jtag_reg_master.sv
// tb/tb_jtag_reg_master.sv - directed self-checking bench for jtag_reg_master
module tb_jtag_reg_master;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtag_reg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    jtag_reg_master #(
        .CPCI_NF2_ADDR_WIDTH(AW),
        .CPCI_NF2_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_DATA(32'hDEAD_0000)
    ) dut (
        .core_clk(clk),
        .reset_n(rst_n),
        .bus(bus_if.master)
    );

    // Show-ahead FIFO model, reset together with the DUT
    logic          f_rw   [16];
    logic [AW-1:0] f_addr [16];
    logic [DW-1:0] f_data [16];
    logic [3:0]    wr_idx;
    logic [3:0]    rd_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_idx <= wr_idx;
        else if (bus_if.fifo_rd_en && rd_idx != wr_idx) rd_idx <= rd_idx + 4'd1;
    end

    assign bus_if.fifo_empty  = (rd_idx == wr_idx);
    assign bus_if.bus_rd_wr_L = f_rw[rd_idx];
    assign bus_if.bus_addr    = f_addr[rd_idx];
    assign bus_if.bus_wr_data = f_data[rd_idx];

    // Responder: acks when the request has been high for ack_delay earlier cycles
    int            ack_delay;
    int            req_cycle;
    logic [DW-1:0] rsp_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_cycle <= 0;
        else if (bus_if.reg_req) req_cycle <= req_cycle + 1;
        else req_cycle <= 0;
    end

    assign bus_if.reg_ack     = bus_if.reg_req && (ack_delay >= 0) && (req_cycle == ack_delay);
    assign bus_if.reg_rd_data = rsp_data;

    int checks = 0;
    int errors = 0;

    int            cyc, rd_en_cnt, vld_cnt, vld_cyc, rise_cnt, req_len_cur, req_len_last;
    int            busy_fall_cyc, bad_cnt;
    int            rd_en_cyc [8];
    int            rise_cyc  [8];
    logic [AW-1:0] rise_addr [8];
    logic          rise_rw   [8];
    logic [DW-1:0] vld_data;
    logic          prev_req, prev_busy;
    logic          exp_rw;
    logic [DW-1:0] exp_wd;

    task automatic push(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        f_rw[wr_idx]   = rw;
        f_addr[wr_idx] = a;
        f_data[wr_idx] = d;
        wr_idx         = wr_idx + 4'd1;
    endtask

    task automatic clear_mon();
        cyc = 0; rd_en_cnt = 0; vld_cnt = 0; vld_cyc = -1; rise_cnt = 0;
        req_len_cur = 0; req_len_last = -1; busy_fall_cyc = -1; bad_cnt = 0;
        vld_data = '0; prev_req = bus_if.reg_req; prev_busy = bus_if.busy;
        for (int i = 0; i < 8; i++) begin
            rd_en_cyc[i] = -1; rise_cyc[i] = -1; rise_addr[i] = '0; rise_rw[i] = 1'b0;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (bus_if.fifo_rd_en) begin
                if (rd_en_cnt < 8) rd_en_cyc[rd_en_cnt] = cyc;
                rd_en_cnt++;
            end
            if (bus_if.reg_req && !prev_req) begin
                if (rise_cnt < 8) begin
                    rise_cyc[rise_cnt]  = cyc;
                    rise_addr[rise_cnt] = bus_if.reg_addr;
                    rise_rw[rise_cnt]   = bus_if.reg_rd_wr_L;
                end
                rise_cnt++;
                req_len_cur = 0;
            end
            if (bus_if.reg_req) begin
                req_len_cur++;
                if (bus_if.reg_rd_wr_L !== exp_rw || (!exp_rw && bus_if.reg_wr_data !== exp_wd))
                    bad_cnt++;
            end
            if (!bus_if.reg_req && prev_req) req_len_last = req_len_cur;
            if (bus_if.bus_rd_vld) begin
                vld_cnt++;
                vld_cyc  = cyc;
                vld_data = bus_if.bus_rd_data;
            end
            if (!bus_if.busy && prev_busy) busy_fall_cyc = cyc;
            prev_req  = bus_if.reg_req;
            prev_busy = bus_if.busy;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus_if.reg_req !== 1'b0 || bus_if.fifo_rd_en !== 1'b0 || bus_if.bus_rd_vld !== 1'b0 ||
            bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: req=%b rd_en=%b vld=%b busy=%b, required all 0",
                     bus_if.reg_req, bus_if.fifo_rd_en, bus_if.bus_rd_vld, bus_if.busy);
        end
        checks++;
        if (bus_if.reg_rd_wr_L !== 1'b1) begin
            errors++;
            $display("FAIL reset_rd_wr_L: got %b required 1", bus_if.reg_rd_wr_L);
        end
        checks++;
        if (bus_if.reg_addr !== '0 || bus_if.reg_wr_data !== '0 || bus_if.bus_rd_data !== '0 ||
            bus_if.timeout_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wd=%h rd=%h tc=%0d, required all 0",
                     bus_if.reg_addr, bus_if.reg_wr_data, bus_if.bus_rd_data, bus_if.timeout_count);
        end
        rst_n = 1'b1;
        clear_mon();
        step(4);
        checks++;
        if (rd_en_cnt != 0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty_fifo: rd_en pulses=%0d busy=%b, required 0 and 0",
                     rd_en_cnt, bus_if.busy);
        end
    endtask

    task automatic test_single_read();
        clear_mon();
        ack_delay = 0; rsp_data = 32'hCAFEF00D; exp_rw = 1'b1; exp_wd = '0;
        push(1'b1, 27'h0000040, 32'h0);
        step(10);
        checks++;
        if (rd_en_cnt != 1) begin
            errors++; $display("FAIL read_rd_en_count: got %0d required 1", rd_en_cnt);
        end
        checks++;
        if (rise_addr[0] !== 27'h0000040 || rd_en_cyc[0] != rise_cyc[0]) begin
            errors++;
            $display("FAIL read_issue: addr=%h rd_en_cyc=%0d rise_cyc=%0d, required 0000040 and equal",
                     rise_addr[0], rd_en_cyc[0], rise_cyc[0]);
        end
        checks++;
        if (vld_cnt != 1 || vld_cyc - rise_cyc[0] != 1 || vld_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL read_return: vld=%0d offset=%0d data=%h, required 1, 1, cafef00d",
                     vld_cnt, vld_cyc - rise_cyc[0], vld_data);
        end
        checks++;
        if (busy_fall_cyc - rise_cyc[0] != 2) begin
            errors++;
            $display("FAIL read_busy_fall: offset=%0d required 2", busy_fall_cyc - rise_cyc[0]);
        end
    endtask

    task automatic test_write_delayed_ack();
        clear_mon();
        ack_delay = 5; exp_rw = 1'b0; exp_wd = 32'h12345678;
        push(1'b0, 27'h0000100, 32'h12345678);
        step(14);
        checks++;
        if (req_len_last != 6) begin
            errors++; $display("FAIL write_req_len: got %0d required 6", req_len_last);
        end
        checks++;
        if (bad_cnt != 0 || rise_addr[0] !== 27'h0000100) begin
            errors++;
            $display("FAIL write_bus_stable: bad cycles=%0d addr=%h, required 0 and 0000100",
                     bad_cnt, rise_addr[0]);
        end
        checks++;
        if (vld_cnt != 0) begin
            errors++; $display("FAIL write_no_return: got %0d strobes required 0", vld_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ea [4];
        logic          er [4];
        ea[0] = 27'h10; ea[1] = 27'h20; ea[2] = 27'h30; ea[3] = 27'h40;
        er[0] = 1'b1;   er[1] = 1'b0;   er[2] = 1'b1;   er[3] = 1'b0;
        clear_mon();
        ack_delay = 0; rsp_data = 32'h11112222;
        exp_rw = 1'b0; exp_wd = '0;
        push(1'b1, ea[0], 32'h0);
        push(1'b0, ea[1], 32'hA5A5A5A5);
        push(1'b1, ea[2], 32'h0);
        push(1'b0, ea[3], 32'h5A5A5A5A);
        step(20);
        checks++;
        if (rd_en_cnt != 4) begin
            errors++; $display("FAIL b2b_rd_en_count: got %0d required 4", rd_en_cnt);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rd_en_cyc[i] - rd_en_cyc[i-1] != 3) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d required 3", i, rd_en_cyc[i] - rd_en_cyc[i-1]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rise_addr[i] !== ea[i] || rise_rw[i] !== er[i]) begin
                errors++;
                $display("FAIL b2b_order[%0d]: addr=%h rw=%b required %h %b",
                         i, rise_addr[i], rise_rw[i], ea[i], er[i]);
            end
        end
        checks++;
        if (vld_cnt != 2 || vld_data !== 32'h11112222) begin
            errors++;
            $display("FAIL b2b_returns: got %0d data %h required 2 11112222", vld_cnt, vld_data);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        ack_delay = -1; exp_rw = 1'b1;
        push(1'b1, 27'h0000050, 32'h0);
        step(14);
        checks++;
        if (req_len_last != TO) begin
            errors++; $display("FAIL timeout_req_len: got %0d required %0d", req_len_last, TO);
        end
        checks++;
        if (vld_cnt != 1 || vld_data !== 32'hDEAD0000 || vld_cyc - rise_cyc[0] != TO) begin
            errors++;
            $display("FAIL timeout_return: vld=%0d data=%h offset=%0d required 1 dead0000 %0d",
                     vld_cnt, vld_data, vld_cyc - rise_cyc[0], TO);
        end
        checks++;
        if (bus_if.timeout_count !== 8'd1) begin
            errors++; $display("FAIL timeout_count_1: got %0d required 1", bus_if.timeout_count);
        end
    endtask

    task automatic test_ack_boundary();
        clear_mon();
        ack_delay = TO - 1; rsp_data = 32'h0BADCAFE; exp_rw = 1'b1;
        push(1'b1, 27'h0000060, 32'h0);
        step(14);
        checks++;
        if (vld_cnt != 1 || vld_data !== 32'h0BADCAFE || req_len_last != TO) begin
            errors++;
            $display("FAIL boundary_return: vld=%0d data=%h len=%0d required 1 0badcafe %0d",
                     vld_cnt, vld_data, req_len_last, TO);
        end
        checks++;
        if (bus_if.timeout_count !== 8'd1) begin
            errors++; $display("FAIL boundary_count: got %0d required 1", bus_if.timeout_count);
        end
    endtask

    task automatic test_timeout_saturate();
        ack_delay = -1; exp_rw = 1'b1;
        for (int i = 2; i <= 300; i++) begin
            push(1'b1, 27'h0000070, 32'h0);
            step(12);
            if (i == 254 || i == 255 || i == 300) begin
                checks++;
                if (bus_if.timeout_count !== 8'((i > 255) ? 255 : i)) begin
                    errors++;
                    $display("FAIL timeout_saturate[%0d]: got %0d required %0d",
                             i, bus_if.timeout_count, (i > 255) ? 255 : i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        ack_delay = -1; exp_rw = 1'b1;
        push(1'b1, 27'h0000080, 32'h0);
        step(4);
        checks++;
        if (bus_if.reg_req !== 1'b1 || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: req=%b busy=%b required 1 1", bus_if.reg_req, bus_if.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.reg_req !== 1'b0 || bus_if.fifo_rd_en !== 1'b0 || bus_if.bus_rd_vld !== 1'b0 ||
            bus_if.busy !== 1'b0 || bus_if.timeout_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_async: req=%b rd_en=%b vld=%b busy=%b tc=%0d required all 0",
                     bus_if.reg_req, bus_if.fifo_rd_en, bus_if.bus_rd_vld, bus_if.busy,
                     bus_if.timeout_count);
        end
        clear_mon();
        step(3);
        rst_n = 1'b1;
        step(5);
        checks++;
        if (vld_cnt != 0 || rd_en_cnt != 0) begin
            errors++;
            $display("FAIL midreset_quiet: vld=%0d rd_en=%0d required 0 0", vld_cnt, rd_en_cnt);
        end
        clear_mon();
        ack_delay = 2; rsp_data = 32'h600DF00D;
        push(1'b1, 27'h0000090, 32'h0);
        step(10);
        checks++;
        if (vld_cnt != 1 || vld_data !== 32'h600DF00D || req_len_last != 3 ||
            rise_addr[0] !== 27'h0000090) begin
            errors++;
            $display("FAIL midreset_recover: vld=%0d data=%h len=%0d addr=%h required 1 600df00d 3 0000090",
                     vld_cnt, vld_data, req_len_last, rise_addr[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_idx = '0;
        ack_delay = 0;
        rsp_data = '0;
        exp_rw = 1'b1;
        exp_wd = '0;
        for (int i = 0; i < 16; i++) begin
            f_rw[i] = 1'b0; f_addr[i] = '0; f_data[i] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_single_read();
        test_write_delayed_ack();
        test_back_to_back();
        test_timeout();
        test_ack_boundary();
        test_timeout_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
